right_shift_seq: RTL

RIGHT_SHIFT_SEQ -- requirements
Module: right_shift_seq

---
 rtl/right_shift_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/right_shift_seq.sv
// Sequential right shifter: one barrel stage per cycle, result after SHAMT_W stages.
// Optional rotate mode is compiled in when RIGHT_SHIFT_ROTATE_EN is defined.
module right_shift_seq #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  a,
    input  logic [SHAMT_W-1:0] b,
    input  logic               arith,
    input  logic               rot,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  w,
    output logic               busy
);

    localparam int K_W = $clog2(SHAMT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              state, state_nx;
    logic [K_W-1:0]      k;
    logic [DATA_W-1:0]   work;
    logic [DATA_W-1:0]   stage_res;
    logic [DATA_W-1:0]   fill;
    logic [SHAMT_W-1:0]  b_q;
    logic [SHAMT_W-1:0]  step;
    logic [SHAMT_W:0]    lsh;
    logic                arith_q;
    logic                sign_q;
    logic                last_stage;

`ifdef RIGHT_SHIFT_ROTATE_EN
    logic rot_q;
`else
    logic unused_rot;
    assign unused_rot = rot;
`endif

    assign last_stage = (k == K_W'(SHAMT_W - 1));
    assign w          = work;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_stage) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Stage k shifts by 2**k; the fill word is OR-ed in from the top so that
    // logical, arithmetic and rotate share one shifter.
    always_comb begin
`ifdef RIGHT_SHIFT_ROTATE_EN
        fill = rot_q ? work : {DATA_W{arith_q & sign_q}};
`else
        fill = {DATA_W{arith_q & sign_q}};
`endif
        step      = SHAMT_W'(1) << k;
        lsh       = (SHAMT_W + 1)'(DATA_W) - (SHAMT_W + 1)'(step);
        stage_res = work;
        if (b_q[k]) begin
            stage_res = (work >> step) | (fill << lsh);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            k       <= '0;
            b_q     <= '0;
            arith_q <= 1'b0;
            sign_q  <= 1'b0;
`ifdef RIGHT_SHIFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        work    <= a;
                        b_q     <= b;
                        arith_q <= arith;
                        sign_q  <= a[DATA_W-1];
                        k       <= '0;
`ifdef RIGHT_SHIFT_ROTATE_EN
                        rot_q   <= rot;
`endif
                    end
                end
                S_SHIFT: begin
                    work <= stage_res;
                    k    <= k + K_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
